// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: buffers two prior rows of a raster pixel
// stream and emits one 72-bit neighbourhood per accepted pixel once complete.
// Optional o_sof/o_eof sideband ports are built when WINGEN_SIDEBAND_EN is defined.
module window_gen_3x3 #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_valid,
    input  logic [7:0]  i_pixel,
    input  logic        i_sof,
    output logic [71:0] o_window,
    output logic        o_valid
`ifdef WINGEN_SIDEBAND_EN
    ,
    output logic        o_sof,
    output logic        o_eof
`endif
);

    localparam int unsigned PW = 8;
    localparam int unsigned TW = 3 * PW;
    localparam int unsigned WW = 9 * PW;
    localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [PW-1:0] lb0 [IMG_WIDTH];
    logic [PW-1:0] lb1 [IMG_WIDTH];
    logic [PW-1:0] lb0_rd, lb1_rd;
    // Tap 0 is the leftmost column (c-2), tap 2 the current column.
    logic [TW-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic          pend_q, pend_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] win_q, win_d;
`ifdef WINGEN_SIDEBAND_EN
    logic          sof_pend_q, sof_pend_d, eof_pend_q, eof_pend_d;
    logic          sof_q, sof_d, eof_q, eof_d;
`endif

    // Position of the incoming pixel; a qualified sof forces (0,0).
    always_comb begin
        cur_col = (i_sof) ? '0 : col_q;
        cur_row = (i_sof) ? '0 : row_q;
        lb0_rd  = lb0[cur_col];
        lb1_rd  = lb1[cur_col];
    end

    // Next-state: counters, tap shift, window-pending flag, output stage.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        pend_d  = 1'b0;
        valid_d = pend_q;
        win_d   = (pend_q) ? {bot_q, mid_q, top_q} : win_q;
`ifdef WINGEN_SIDEBAND_EN
        sof_pend_d = 1'b0;
        eof_pend_d = 1'b0;
        sof_d      = pend_q & sof_pend_q;
        eof_d      = pend_q & eof_pend_q;
`endif
        if (i_valid) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            top_d  = {lb0_rd,  top_q[TW-1:PW]};
            mid_d  = {lb1_rd,  mid_q[TW-1:PW]};
            bot_d  = {i_pixel, bot_q[TW-1:PW]};
            pend_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
`ifdef WINGEN_SIDEBAND_EN
            sof_pend_d = (cur_row == RW'(2)) && (cur_col == CW'(2));
            eof_pend_d = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            win_q   <= '0;
`ifdef WINGEN_SIDEBAND_EN
            sof_pend_q <= 1'b0;
            eof_pend_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
`endif
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            win_q   <= win_d;
`ifdef WINGEN_SIDEBAND_EN
            sof_pend_q <= sof_pend_d;
            eof_pend_q <= eof_pend_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
`endif
        end
    end

    // Line buffers (not reset): LB0 takes the old row r-1, LB1 the new pixel.
    always_ff @(posedge CLK) begin
        if (RST && i_valid) begin
            lb0[cur_col] <= lb1_rd;
            lb1[cur_col] <= i_pixel;
        end
    end

    assign o_window = win_q;
    assign o_valid  = valid_q;
`ifdef WINGEN_SIDEBAND_EN
    assign o_sof    = sof_q;
    assign o_eof    = eof_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 against a frame-image reference model.
module tb_window_gen_3x3;

    localparam int unsigned W = 5;
    localparam int unsigned H = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_valid;
    logic [7:0]  i_pixel;
    logic        i_sof;
    logic [71:0] o_window;
    logic        o_valid;
`ifdef WINGEN_SIDEBAND_EN
    logic        o_sof;
    logic        o_eof;
`endif

    always #5 CLK = ~CLK;

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .i_valid  (i_valid),
        .i_pixel  (i_pixel),
        .i_sof    (i_sof),
        .o_window (o_window),
        .o_valid  (o_valid)
`ifdef WINGEN_SIDEBAND_EN
        ,
        .o_sof    (o_sof),
        .o_eof    (o_eof)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the received image plus position and the pending window.
    logic [7:0]  img [H][W];
    int          m_row = 0;
    int          m_col = 0;
    bit          pend_v = 0;
    bit          pend_sof = 0;
    bit          pend_eof = 0;
    logic [71:0] pend_win = '0;
    logic [71:0] last_win = '0;
    int          win_count = 0;
    bit          got_first = 0;
    logic [71:0] first_win = '0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [7:0] p, input bit s);
        int r, c;
        r = s ? 0 : m_row;
        c = s ? 0 : m_col;
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
            pend_v = 1;
            for (int ry = 0; ry < 3; ry++)
                for (int cx = 0; cx < 3; cx++)
                    pend_win[(3*ry+cx)*8 +: 8] = img[r-2+ry][c-2+cx];
            pend_sof = (r == 2 && c == 2);
            pend_eof = (r == int'(H) - 1 && c == int'(W) - 1);
        end
        c++;
        if (c == int'(W)) begin
            c = 0;
            r++;
            if (r == int'(H)) r = 0;
        end
        m_row = r;
        m_col = c;
    endtask

    // One clock: drive inputs, sample #1 after the edge, then advance the model.
    task automatic step(input bit v, input logic [7:0] p, input bit s, input bit rn);
        RST     = rn;
        i_valid = v;
        i_pixel = p;
        i_sof   = s;
        @(posedge CLK);
        #1;
        if (!rn) begin
            check_eq("rst_valid", 72'(o_valid), 72'd0);
            check_eq("rst_window", o_window, 72'd0);
`ifdef WINGEN_SIDEBAND_EN
            check_eq("rst_sof", 72'(o_sof), 72'd0);
            check_eq("rst_eof", 72'(o_eof), 72'd0);
`endif
            pend_v = 0; pend_sof = 0; pend_eof = 0;
            last_win = '0;
            m_row = 0; m_col = 0;
        end else begin
            check_eq("valid", 72'(o_valid), 72'(pend_v));
            if (pend_v) last_win = pend_win;
            check_eq("window", o_window, last_win);
`ifdef WINGEN_SIDEBAND_EN
            check_eq("o_sof", 72'(o_sof), 72'(pend_v && pend_sof));
            check_eq("o_eof", 72'(o_eof), 72'(pend_v && pend_eof));
`endif
            if (o_valid) begin
                win_count++;
                if (!got_first) begin
                    got_first = 1;
                    first_win = o_window;
                end
            end
            pend_v = 0; pend_sof = 0; pend_eof = 0;
            if (v) model_accept(p, s);
        end
    endtask

    // mode 0: ramp row*16+col, 1: random, 2: constant 0x80.
    task automatic run_frame(input int mode, input int max_gap, input bit first_sof);
        logic [7:0] p;
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                int gap;
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                repeat (gap) step(0, 8'($urandom), 0, 1);
                case (mode)
                    0:       p = 8'(r * 16 + c);
                    1:       p = 8'($urandom);
                    default: p = 8'h80;
                endcase
                step(1, p, first_sof && r == 0 && c == 0, 1);
            end
        end
    endtask

    task automatic begin_section();
        win_count = 0;
        got_first = 0;
    endtask

    initial begin
        RST = 1'b0; i_valid = 1'b0; i_pixel = '0; i_sof = 1'b0;
        repeat (3) step(0, 8'h00, 0, 0);

        // First window from a continuous ramp frame.
        begin_section();
        run_frame(0, 0, 1);
        repeat (2) step(0, 8'h00, 0, 1);
        check_eq("first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
        check_eq("frame_windows", 72'(win_count), 72'd6);

        // Same frame with random input gaps.
        begin_section();
        run_frame(0, 3, 1);
        repeat (2) step(0, 8'h00, 0, 1);
        check_eq("gap_first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
        check_eq("gap_frame_windows", 72'(win_count), 72'd6);

        // Mid-frame reset after 9 pixels, then a fresh frame.
        for (int k = 0; k < 9; k++) step(1, 8'($urandom), k == 0, 1);
        step(0, 8'h00, 0, 0);
        begin_section();
        run_frame(0, 0, 1);
        repeat (2) step(0, 8'h00, 0, 1);
        check_eq("rst_first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
        check_eq("rst_frame_windows", 72'(win_count), 72'd6);

        // Resync: sof on pixel 7 of a frame restarts at (0,0).
        for (int k = 0; k < 7; k++) step(1, 8'($urandom), k == 0, 1);
        begin_section();
        run_frame(1, 0, 1);
        repeat (2) step(0, 8'h00, 0, 1);
        check_eq("resync_windows", 72'(win_count), 72'd6);

        // Two back-to-back frames with no sof: wrap is automatic.
        begin_section();
        run_frame(1, 2, 0);
        run_frame(1, 2, 0);
        repeat (2) step(0, 8'h00, 0, 1);
        check_eq("wrap_windows", 72'(win_count), 72'd12);

        // Flat 0x80 frame: every tap equals the input level.
        begin_section();
        run_frame(2, 1, 1);
        repeat (2) step(0, 8'h00, 0, 1);
        check_eq("flat_window", first_win, {9{8'h80}});
        check_eq("flat_windows", 72'(win_count), 72'd6);
        check_eq("flat_last", o_window, {9{8'h80}});

        // Random stress: gaps, stray sof (with and without valid), rare resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) != 0));
        end
        repeat (2) step(0, 8'h00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 window generator that sits directly upstream of the Gaussian blur stage. It accepts a raster-order 8-bit pixel stream, buffers the two previous image rows in internal line buffers, and emits one 72-bit 3x3 neighbourhood per accepted pixel once a full window exists. The output matches the blur stage's `i_data`/`i_valid` input exactly.

## Interface
- `IMG_WIDTH`, 640, pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, 480, rows per frame; must be ≥ 3.
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `i_valid`  in  1  `i_pixel` is accepted this cycle.
- `i_pixel`  in  8  unsigned pixel, raster order.
- `i_sof`  in  1  start of frame; qualified by `i_valid`.
- `o_window`  out  72  3x3 window; byte k at `[k*8+:8]`.
- `o_valid`  out  1  `o_window` is new this cycle.
- `o_sof`, `o_eof`  out  1 each  present only with `WINGEN_SIDEBAND_EN`.

## Operation
- Column counter `col` counts 0..IMG_WIDTH-1. Row counter `row` counts 0..IMG_HEIGHT-1. Both advance only on `i_valid`.
- `col` wraps to 0 and increments `row`. After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0, and the next frame needs no `i_sof`.
- `i_valid & i_sof`: the pixel is treated as (0,0), whatever the counter state. The next pixel is (0,1). `i_sof` without `i_valid` is ignored.
- Line buffers: two IMG_WIDTH x 8 arrays. LB1 holds row r-1 and LB0 holds row r-2.
- On each accepted pixel at column c:
  - read LB1[c] and LB0[c] (read-before-write);
  - then write LB0[c] ← old LB1[c] and LB1[c] ← `i_pixel`.
- Three 3-tap column shift registers, one per row (r-2, r-1, r), shift on every accepted pixel.
- A window is emitted when the accepted pixel has `row ≥ 2` and `col ≥ 2`. Its centre is (row-1, col-1).
- Windows are emitted per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- No windows at `col` 0/1. Stale taps from the previous row are never output.
- Byte packing: k = 3*ry + cx.
  - ry 0 = oldest row (r-2), 2 = current row.
  - cx 0 = leftmost (c-2), 2 = current column.
  - `[7:0]` = top-left, `[71:64]` = bottom-right (current pixel).
- Input gaps (`i_valid`=0) of any length are allowed. State is frozen and `o_window` holds its last value.
- No backpressure. The downstream stage accepts every `o_valid`.

## Timing
- Latency is 1 cycle: the window completed by the pixel accepted at edge N is on `o_window` with `o_valid`=1 after edge N+1.
- Throughput: one pixel per cycle sustained.
- `o_valid` is a single-cycle pulse per window. Consecutive pixels give back-to-back `o_valid`.
- Reset values:
  - `o_valid`=0, `o_window`=0, `o_sof`=0, `o_eof`=0;
  - `col`=0, `row`=0, shift registers 0;
  - line buffer contents are not reset; they are unused until rewritten.
- Reset mid-frame: the next accepted pixel is (0,0), and no window is emitted until two full rows have been re-received.
- `i_sof` mid-frame behaves like reset for counters only. Line buffers are not cleared, but are unused until rewritten.

## Configuration
- `WINGEN_SIDEBAND_EN` defined:
  - `o_sof` = 1 with the window centred at (1,1), else 0.
  - `o_eof` = 1 with the window centred at (IMG_HEIGHT-2, IMG_WIDTH-2), else 0.
  - Both are registered alongside `o_valid` and are never 1 while `o_valid`=0.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- **First window.** W=5, H=4, ramp pixel = row*16+col, continuous `i_valid`, first pixel with `i_sof`. First `o_valid` one cycle after pixel 13 (row 2, col 2); `o_window` = 0x22_21_20_12_11_10_02_01_00. Exactly 6 `o_valid` pulses per frame.
- **Input gaps.** Same frame with random 0–3 cycle `i_valid` gaps. Identical window sequence; each `o_valid` exactly 1 cycle after its pixel.
- **Mid-frame reset.** Assert RST for 1 cycle after 9 pixels. Outputs read 0 next cycle. A fresh frame then yields the first-window result above unchanged.
- **Resync and wrap.** `i_sof` asserted on pixel 7 of a frame: that pixel is (0,0), and the first window appears after 12 further pixels. Back-to-back frames with no `i_sof`: 12 windows over 2 frames, no window at cols 0/1.
- **Sideband.** With `WINGEN_SIDEBAND_EN`: `o_sof` on window 1 only; `o_eof` on window 6 only, `o_window[71:64]`=0x34.
- **Chained with blur stage.** Constant pixel 0x80 frame feeding the blur stage. Blur output is 0x80 for every window.
